// File: rtl/ahb_sram_slave.sv
`default_nettype none
// ============================================================================
// Module   : ahb_sram_slave
// Purpose  : AHB-Lite slave fronting a 32-bit word SRAM array. It supports
//            byte/halfword/word writes with little-endian lane selection and
//            full-word reads. It inserts WAIT_CYCLES wait states per OKAY
//            transfer and gives a two-cycle ERROR response to misaligned,
//            oversize or out-of-range transfers.
// Ports    : hclk        - clock, rising edge
//            hreset      - asynchronous active-high reset
//            hsel        - slave select
//            hwrite      - 1 = write, 0 = read
//            hready      - bus-wide ready (previous data phase completing)
//            hsize       - 0 byte, 1 halfword, 2 word
//            htrans      - 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
//            hburst      - burst type (not used; beats are independent)
//            haddr       - byte address
//            hwdata      - write data, valid in data phase
//            hready_resp - slave ready, low during wait states
//            hresp       - 00 OKAY, 01 ERROR
//            hrdata      - read data, zero unless completing a legal read
// Revision : 1.0 - initial release
// ============================================================================
module ahb_sram_slave #(
    parameter int ADDR_W      = 12,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic        hsel,
    input  logic        hwrite,
    input  logic        hready,
    input  logic [2:0]  hsize,
    input  logic [1:0]  htrans,
    input  logic [2:0]  hburst,
    input  logic [31:0] haddr,
    input  logic [31:0] hwdata,
    output logic        hready_resp,
    output logic [1:0]  hresp,
    output logic [31:0] hrdata
);

    localparam int         IDX_W      = ADDR_W - 2;
    localparam int         DEPTH      = 1 << IDX_W;
    localparam logic [2:0] WAIT_LAST  = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_t;

    state_t           state;
    logic [2:0]       wait_cnt;

    // Data-phase control captured from the accepted address phase
    logic             dp_valid;
    logic             dp_write;
    logic [1:0]       dp_size;
    logic [1:0]       dp_off;
    logic [IDX_W-1:0] dp_idx;

    logic [31:0]      mem [DEPTH];

    logic             accept;
    logic             legal;
    logic             commit;
    logic [3:0]       wr_lanes;
    logic [31:0]      wr_bits;
    logic [IDX_W-1:0] addr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [31:0]      rd_word;
    logic [31:0]      fwd_word;

    // Burst type and the SEQ/NONSEQ distinction carry no meaning here
    logic             unused_inputs;
    assign unused_inputs = ^{hburst, htrans[0]};

    assign addr_idx = haddr[ADDR_W-1:2];

    // Address phases are only sampled while this slave is not stalling
    assign accept = hready_resp && hsel && hready && htrans[1];

    assign legal = (hsize <= 3'd2)
                && !((hsize == 3'd1) && haddr[0])
                && !((hsize == 3'd2) && (haddr[1:0] != 2'b00))
                && ((haddr >> ADDR_W) == 32'd0);

    // A write lands on the cycle its data phase completes
    assign commit = hready_resp && dp_valid && dp_write;

    always_comb begin
        wr_lanes = 4'b0000;
        case (dp_size)
            2'd0:    wr_lanes = 4'b0001 << dp_off;
            2'd1:    wr_lanes = dp_off[1] ? 4'b1100 : 4'b0011;
            default: wr_lanes = 4'b1111;
        endcase
    end

    assign wr_bits = {{8{wr_lanes[3]}}, {8{wr_lanes[2]}}, {8{wr_lanes[1]}}, {8{wr_lanes[0]}}};

    // In WAIT the pending read is fetched; otherwise the incoming address
    assign rd_idx  = (state == ST_WAIT) ? dp_idx : addr_idx;
    assign rd_word = mem[rd_idx];

    // A read issued alongside the completing write of the same word sees
    // the merged post-write value
    assign fwd_word = (commit && (dp_idx == rd_idx))
                    ? ((hwdata & wr_bits) | (rd_word & ~wr_bits))
                    : rd_word;

    // Array contents are deliberately not reset
    always_ff @(posedge hclk) begin
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_lanes[i]) begin
                    mem[dp_idx][8*i +: 8] <= hwdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state       <= ST_IDLE;
            wait_cnt    <= 3'd0;
            dp_valid    <= 1'b0;
            dp_write    <= 1'b0;
            dp_size     <= 2'd0;
            dp_off      <= 2'd0;
            dp_idx      <= '0;
            hready_resp <= 1'b1;
            hresp       <= RESP_OKAY;
            hrdata      <= 32'd0;
        end else begin
            case (state)
                ST_IDLE, ST_ERR2: begin
                    if (accept && legal) begin
                        dp_valid <= 1'b1;
                        dp_write <= hwrite;
                        dp_size  <= hsize[1:0];
                        dp_off   <= haddr[1:0];
                        dp_idx   <= addr_idx;
                        hresp    <= RESP_OKAY;
                        if (WAIT_CYCLES == 0) begin
                            state       <= ST_IDLE;
                            hready_resp <= 1'b1;
                            hrdata      <= hwrite ? 32'd0 : fwd_word;
                        end else begin
                            state       <= ST_WAIT;
                            wait_cnt    <= 3'd0;
                            hready_resp <= 1'b0;
                            hrdata      <= 32'd0;
                        end
                    end else if (accept) begin
                        state       <= ST_ERR1;
                        dp_valid    <= 1'b0;
                        hready_resp <= 1'b0;
                        hresp       <= RESP_ERROR;
                        hrdata      <= 32'd0;
                    end else begin
                        state       <= ST_IDLE;
                        dp_valid    <= 1'b0;
                        hready_resp <= 1'b1;
                        hresp       <= RESP_OKAY;
                        hrdata      <= 32'd0;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        state       <= ST_IDLE;
                        wait_cnt    <= 3'd0;
                        hready_resp <= 1'b1;
                        hrdata      <= dp_write ? 32'd0 : rd_word;
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end
                ST_ERR1: begin
                    state       <= ST_ERR2;
                    hready_resp <= 1'b1;
                    hresp       <= RESP_ERROR;
                    hrdata      <= 32'd0;
                end
                default: begin
                    state       <= ST_IDLE;
                    dp_valid    <= 1'b0;
                    hready_resp <= 1'b1;
                    hresp       <= RESP_OKAY;
                    hrdata      <= 32'd0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/ahb_sram_slave.md
AHB_SRAM_SLAVE -- requirements
Module: ahb_sram_slave

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 12, giving the byte-address width decoded; the array holds 2^(ADDR_W-2) 32-bit words.
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 0, giving the wait states inserted in every OKAY data phase (0..7).
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-004 Ports SHALL be:
  hclk         in   1   clock, all logic on rising edge
  hreset       in   1   asynchronous active-high reset
  hsel         in   1   slave select
  hwrite       in   1   1=write, 0=read
  hready       in   1   bus ready; previous data phase completing
  hsize        in   3   transfer size (0 byte, 1 half, 2 word)
  htrans       in   2   00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
  hburst       in   3   burst type, ignored
  haddr        in   32  byte address
  hwdata       in   32  write data, valid in data phase
  hready_resp  out  1   slave ready; low = wait state
  hresp        out  2   00 OKAY, 01 ERROR
  hrdata       out  32  read data

Function
REQ-005 A transfer SHALL be accepted on a rising edge with hsel=1, hready=1, htrans[1]=1; haddr, hwrite and hsize are registered for the data phase.
REQ-006 IDLE/BUSY, or hsel=0, SHALL produce a zero-wait OKAY data phase with no array access.
REQ-007 An accepted transfer SHALL be illegal if hsize>2, hsize=1 with haddr[0]=1, hsize=2 with haddr[1:0]!=0, or haddr[31:ADDR_W]!=0.
REQ-008 The FSM SHALL have states IDLE, WAIT, ERR1, ERR2.
REQ-009 IDLE: legal accept with WAIT_CYCLES=0 -> stay IDLE (zero-wait); legal accept with WAIT_CYCLES>0 -> WAIT; illegal accept -> ERR1.
REQ-010 WAIT: hready_resp=0, hresp=00; a counter counts WAIT_CYCLES cycles, then -> IDLE, where the completing cycle has hready_resp=1.
REQ-011 ERR1: hready_resp=0, hresp=01; always -> ERR2 next cycle.
REQ-012 ERR2: hready_resp=1, hresp=01; accept/decode rules of IDLE apply to the new address phase this cycle.
REQ-013 Illegal transfers SHALL NOT modify the array; erroneous reads SHALL drive hrdata=0.
REQ-014 While hready_resp=0, the block SHALL ignore address-phase inputs (hready is low bus-wide).
REQ-015 A write SHALL commit on the data-phase cycle with hready_resp=1, using hwdata of that cycle.
REQ-016 Byte lanes SHALL be little-endian: byte -> lane haddr[1:0]; halfword -> lanes {haddr[1],0} and {haddr[1],1}; word -> all four; other lanes unchanged.
REQ-017 A read SHALL drive the full 32-bit word at haddr[ADDR_W-1:2] on hrdata in its data-phase cycle with hready_resp=1, irrespective of hsize.
REQ-018 A read whose address phase coincides with the data phase of a write to the same word SHALL return the post-write word (forwarded, merged per lane).
REQ-019 hrdata SHALL be 0 in every cycle not completing a legal read.
REQ-020 Successive SEQ beats SHALL be handled as independent single transfers; address wrap/increment is the initiator's responsibility.
REQ-021 RETRY and SPLIT responses SHALL never be generated.

Reset
REQ-022 While hreset=1: FSM=IDLE, wait counter=0, registered data-phase control cleared (no pending transfer), hready_resp=1, hresp=00, hrdata=0.
REQ-023 Array contents SHALL NOT be reset; a write pending in WAIT or in its data phase when hreset asserts SHALL NOT commit.
REQ-024 After reset deassertion, the first rising edge SHALL be able to accept a transfer.

Verification
REQ-025 Word write 0xDEADBEEF to 0x010, then read 0x010 (WAIT_CYCLES=0) -> both zero-wait OKAY, hrdata=0xDEADBEEF.
REQ-026 Byte write 0xAA at 0x013 over 0x11223344, read 0x010 -> hrdata=0xAA223344; halfword write 0x5566 at 0x012 -> 0x55663344.
REQ-027 Word write at 0x002 -> ERR1 (hready_resp=0, hresp=01), ERR2 (hready_resp=1, hresp=01); word at 0x000 unchanged; next transfer OKAY.
REQ-028 haddr=0x1000 with ADDR_W=12 -> two-cycle ERROR, read hrdata=0.
REQ-029 WAIT_CYCLES=2, read 0x020 -> hready_resp low 2 cycles, high on third with correct data, hresp=00 throughout.
REQ-030 Write 0x12345678 to 0x040 immediately followed by read 0x040 -> read returns 0x12345678; hreset pulse during WAIT of a write -> outputs at reset values, word unchanged.
